// File: rtl/btn_input_bank.sv
// btn_input_bank: N-channel push-button front end.
// Each channel has a 2-flop synchroniser, a counter-based debouncer, and
// press/release strobes. An optional hold-to-auto-repeat FSM drives the
// repeat strobes. Channels are independent, and all outputs are registered
// except any_pressed.
module btn_input_bank #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             any_pressed
);

  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] rep_q, rep_d;
  logic [DW-1:0]    dcnt_q [N_BTN];
  logic [DW-1:0]    dcnt_d [N_BTN];
  logic [RW-1:0]    rcnt_q [N_BTN];
  logic [RW-1:0]    rcnt_d [N_BTN];
  rep_state_t       state_q [N_BTN];
  rep_state_t       state_d [N_BTN];

  // Next-state logic for the synchroniser, debouncer and repeat FSM of every channel.
  always_comb begin
    s1_d      = btn_in;
    s2_d      = s1_q;
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    rep_d     = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      dcnt_d[i]  = dcnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      state_d[i] = state_q[i];

      // A single cycle of agreement with the stable level restarts the count.
      if (s2_q[i] == stable_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DCNT_LAST) begin
        stable_d[i] = s2_q[i];
        dcnt_d[i]   = '0;
        if (s2_q[i]) press_d[i]   = 1'b1;
        else         release_d[i] = 1'b1;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end

      // The FSM reacts to the strobe being generated this edge, so the first repeat
      // lands exactly REPEAT_DELAY edges after the press edge. Release takes priority
      // over a terminal count.
      unique case (state_q[i])
        ST_IDLE: begin
          if (press_d[i] && repeat_en[i]) begin
            state_d[i] = ST_DELAY;
            rcnt_d[i]  = '0;
          end
        end
        ST_DELAY: begin
          if (release_d[i] || !repeat_en[i]) begin
            state_d[i] = ST_IDLE;
          end else if (rcnt_q[i] == DELAY_LAST) begin
            rep_d[i]   = 1'b1;
            state_d[i] = ST_REPEAT;
            rcnt_d[i]  = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (release_d[i] || !repeat_en[i]) begin
            state_d[i] = ST_IDLE;
          end else if (rcnt_q[i] == PER_LAST) begin
            rep_d[i]  = 1'b1;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      rep_q     <= '0;
      dcnt_q    <= '{default: '0};
      rcnt_q    <= '{default: '0};
      state_q   <= '{default: ST_IDLE};
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      rep_q     <= rep_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
    end
  end

  assign btn_level     = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = rep_q;
  assign any_pressed   = |stable_q;

endmodule

// File: tb/tb_btn_input_bank.sv
// Directed self-checking bench for btn_input_bank with short debounce/repeat timing.
module tb_btn_input_bank;

  localparam int unsigned N = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] repeat_en;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] repeat_pulse;
  logic         any_pressed;

  int unsigned total = 0;
  int unsigned bad   = 0;

  btn_input_bank #(
    .N_BTN          (5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk_100MHz   (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .repeat_en    (repeat_en),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .any_pressed  (any_pressed)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with all buttons held
    reset     = 1'b1;
    btn_in    = 5'b11111;
    repeat_en = 5'b00000;
    cyc(1);
    chk("rst_outs", {btn_level, press_pulse, release_pulse, repeat_pulse, any_pressed}, 0);
    cyc(1);
    reset = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      cyc(1);
      chk("t1_press", press_pulse, (k == 5) ? 5'b11111 : 5'b00000);
      chk("t1_level", btn_level, (k >= 5) ? 5'b11111 : 5'b00000);
    end
    btn_in = 5'b00000;
    for (int k = 0; k <= 6; k++) begin
      cyc(1);
      chk("t1_release", release_pulse, (k == 5) ? 5'b11111 : 5'b00000);
    end
    chk("t1_any_off", any_pressed, 0);

    // 2: single press on channel 0
    btn_in = 5'b00001;
    for (int k = 0; k <= 6; k++) begin
      cyc(1);
      chk("t2_press", press_pulse, (k == 5) ? 5'b00001 : 5'b00000);
      chk("t2_level", btn_level, (k >= 5) ? 5'b00001 : 5'b00000);
    end
    chk("t2_any", any_pressed, 1);

    // 3: channel 2 bounces every 2 cycles; channel 0 stays held
    for (int k = 0; k < 40; k++) begin
      btn_in[2] = ((k / 2) % 2) == 1;
      cyc(1);
      chk("t3_strobes", {press_pulse, release_pulse, repeat_pulse}, 0);
      chk("t3_level", btn_level, 5'b00001);
    end
    btn_in[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("t3_settle", {press_pulse, release_pulse, repeat_pulse, btn_level}, 5'b00001);
    end
    btn_in = 5'b00000;
    cyc(8);

    // 4: channel 1 auto-repeat; the release edge coincides with a terminal count
    repeat_en = 5'b00010;
    btn_in    = 5'b00010;
    for (int k = 0; k <= 36; k++) begin
      cyc(1);
      chk("t4_press", press_pulse, (k == 5) ? 5'b00010 : 5'b00000);
      chk("t4_repeat", repeat_pulse,
          (k == 15 || k == 18 || k == 21 || k == 24 || k == 27) ? 5'b00010 : 5'b00000);
      chk("t4_release", release_pulse, (k == 30) ? 5'b00010 : 5'b00000);
      if (k == 24) btn_in[1] = 1'b0;
    end
    repeat_en = 5'b00000;

    // 5a: held with repeat disabled, then enable re-raised while still held
    btn_in = 5'b01000;
    for (int k = 0; k <= 44; k++) begin
      repeat_en[3] = (k >= 30);
      cyc(1);
      chk("t5a_press", press_pulse, (k == 5) ? 5'b01000 : 5'b00000);
      chk("t5a_repeat", repeat_pulse, 0);
    end
    btn_in    = 5'b00000;
    repeat_en = 5'b00000;
    cyc(8);

    // 5b: enable dropped just before a terminal count in REPEAT, then re-raised
    repeat_en = 5'b01000;
    btn_in    = 5'b01000;
    for (int k = 0; k <= 40; k++) begin
      cyc(1);
      chk("t5b_repeat", repeat_pulse, (k == 15 || k == 18) ? 5'b01000 : 5'b00000);
      if (k == 20) repeat_en[3] = 1'b0;
      if (k == 25) repeat_en[3] = 1'b1;
    end
    btn_in    = 5'b00000;
    repeat_en = 5'b00000;
    cyc(8);

    // 6: reset during REPEAT on channel 4 with the button held
    repeat_en = 5'b10000;
    btn_in    = 5'b10000;
    for (int k = 0; k <= 20; k++) begin
      cyc(1);
      chk("t6_repeat_pre", repeat_pulse, (k == 15 || k == 18) ? 5'b10000 : 5'b00000);
    end
    reset = 1'b1;
    cyc(1);
    chk("t6_rst_outs", {btn_level, press_pulse, release_pulse, repeat_pulse, any_pressed}, 0);
    cyc(1);
    reset = 1'b0;
    for (int k = 0; k <= 19; k++) begin
      cyc(1);
      chk("t6_press", press_pulse, (k == 5) ? 5'b10000 : 5'b00000);
      chk("t6_repeat", repeat_pulse, (k == 15 || k == 18) ? 5'b10000 : 5'b00000);
      chk("t6_level", btn_level, (k >= 5) ? 5'b10000 : 5'b00000);
    end
    chk("t6_any", any_pressed, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
